// File: rtl/clkgate_ctrl_pkg.sv
// Shared types and elaboration helpers for the clock-gate enable controller.
package clkgate_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StIdleWait = 2'd1,
        StOff      = 2'd2,
        StWake     = 2'd3
    } cg_state_t;

    function automatic bit cg_params_legal(int unsigned idle_cycles, int unsigned wake_cycles);
        return (idle_cycles >= 1) && (wake_cycles >= 1);
    endfunction

    // A single-value window still needs a one-bit counter.
    function automatic int unsigned cg_cnt_width(int unsigned idle_cycles,
                                                 int unsigned wake_cycles);
        int unsigned m;
        m = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/clkgate_ctrl_cnt.sv
// Loadable down-counter with zero flag, shared by the idle and wake windows.
module clkgate_ctrl_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             zero_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clkgate_enable_ctrl.sv
// Idle-detect controller producing the registered enable for a downstream clock-gating cell.
module clkgate_enable_ctrl
    import clkgate_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned GCNT_W      = 16
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              busy,
    input  logic              wake_req,
    input  logic              force_on,
    output logic              E,
    output logic              wake_ack,
    output logic              gated,
    output logic [GCNT_W-1:0] gate_count
);

    localparam int unsigned CntW = cg_cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CntW-1:0] IdleLoad = CntW'(IDLE_CYCLES - 1);
    localparam logic [CntW-1:0] WakeLoad = CntW'(WAKE_CYCLES - 1);

    if (!cg_params_legal(IDLE_CYCLES, WAKE_CYCLES)) begin : g_bad_params
        $error("clkgate_enable_ctrl: IDLE_CYCLES and WAKE_CYCLES must both be >= 1");
    end

    cg_state_t         state_d, state_q;
    logic              act, wake;
    logic              cnt_load, cnt_dec, cnt_zero, gate_inc;
    logic [CntW-1:0]   cnt_val, cnt_unused;
    logic              e_q, wake_ack_q, gated_q;
    logic [GCNT_W-1:0] gate_count_q;

    assign act  = busy | wake_req | force_on;
    assign wake = wake_req | force_on;

    clkgate_ctrl_cnt #(
        .Width (CntW)
    ) u_cnt (
        .clk_i      (CK),
        .rst_ni     (RN),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_unused),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        gate_inc = 1'b0;
        unique case (state_q)
            StRun: begin
                if (!act) begin
                    state_d  = StIdleWait;
                    cnt_load = 1'b1;
                    cnt_val  = IdleLoad;
                end
            end
            StIdleWait: begin
                if (act) begin
                    state_d = StRun;
                end else if (cnt_zero) begin
                    state_d  = StOff;
                    gate_inc = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            // busy is ignored here: the domain has no clock to act on it.
            StOff: begin
                if (wake) begin
                    state_d  = StWake;
                    cnt_load = 1'b1;
                    cnt_val  = WakeLoad;
                end
            end
            StWake: begin
                if (cnt_zero) begin
                    state_d = StRun;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the transition.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q      <= StRun;
            e_q          <= 1'b1;
            wake_ack_q   <= 1'b0;
            gated_q      <= 1'b0;
            gate_count_q <= '0;
        end else begin
            state_q    <= state_d;
            e_q        <= (state_d != StOff);
            wake_ack_q <= (state_d == StRun) || (state_d == StIdleWait);
            gated_q    <= (state_d == StOff);
            if (gate_inc && (gate_count_q != '1)) begin
                gate_count_q <= gate_count_q + GCNT_W'(1);
            end
        end
    end

    assign E          = e_q;
    assign wake_ack   = wake_ack_q;
    assign gated      = gated_q;
    assign gate_count = gate_count_q;

endmodule
